// File: rtl/rom_stream_reader_if.sv
// Command, ROM-port and output-stream signals of rom_stream_reader.
// The reader takes the master view; the command source, ROM and consumer take the slave view.
interface rom_stream_reader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rdata;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, start_addr, length, rom_rdata, m_ready,
    output rom_addr, m_data, m_valid, m_last, busy, done
  );

  modport slave (
    output start, start_addr, length, rom_rdata, m_ready,
    input  rom_addr, m_data, m_valid, m_last, busy, done
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Streams a wrap-around address range of an async-read ROM; first word valid 1 cycle after start.
// Output register holds data, last flag and ROM address while m_valid && !m_ready.
module rom_stream_reader #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_CAPACITY = 64
) (
  input logic                clk,
  input logic                rst_n,
  rom_stream_reader_if.master bus
);
  localparam logic [ADDR_WIDTH:0]   CAP       = (ADDR_WIDTH+1)'(MEM_CAPACITY);
  localparam logic [ADDR_WIDTH:0]   ONE       = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_CAPACITY - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  hs, load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    hs      = valid_q && bus.m_ready;
    load    = (state_q == STREAM) && (rem_q != '0) && (!valid_q || bus.m_ready);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            addr_d  = ADDR_WIDTH'(int'(bus.start_addr) % MEM_CAPACITY);
            rem_d   = (bus.length > CAP) ? CAP : bus.length;
            state_d = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (load) begin
          data_d  = bus.rom_rdata;
          valid_d = 1'b1;
          last_d  = (rem_q == ONE);
          rem_d   = rem_q - ONE;
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
        end else if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        // The final word is never followed by a load, so this edge only retires it.
        if (hs && last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rom_addr = addr_q;
  assign bus.m_data   = data_q;
  assign bus.m_valid  = valid_q;
  assign bus.m_last   = last_q;
  assign bus.busy     = (state_q == STREAM);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: table of commands with ready patterns,
// scoreboard of expected words, plus hand-written reset and back-to-back sequences.
module tb_rom_stream_reader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();
  assign bus.rom_rdata = 16'h1000 + {10'd0, bus.rom_addr};

  rom_stream_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .MEM_CAPACITY(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [5:0] addr;
    logic [6:0] len;
    logic [7:0] pat;
    int         pat_len;
    bit         inject;
    int         exp_busy;
    int         exp_words;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          k, done_k, first_k, busy_cnt;
    bit          prev_stall;
    logic [15:0] pdata;
    logic        plast;
    logic [5:0]  paddr;
    exp_t        e;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = v.addr;
    bus.length     = v.len;
    bus.m_ready    = 1'b1;
    for (int i = 0; i < v.exp_words; i++)
      exp_q.push_back('{16'h1000 + 16'((int'(v.addr) + i) % 64), (i == v.exp_words - 1)});
    k = 0; done_k = -1; first_k = -1; busy_cnt = 0; prev_stall = 1'b0;
    pdata = '0; plast = 1'b0; paddr = '0;
    while (done_k < 0 && k < 400) begin
      @(negedge clk);
      bus.start = v.inject && (k == 2);
      if (bus.start) begin
        bus.start_addr = 6'd33;
        bus.length     = 7'd5;
      end
      check("last_qualified", bus.m_last && !bus.m_valid, 0);
      if (prev_stall) begin
        check("stall_data", bus.m_data, pdata);
        check("stall_last", bus.m_last, plast);
        check("stall_addr", bus.rom_addr, paddr);
      end
      if (bus.busy) busy_cnt++;
      if (bus.m_valid && first_k < 0) begin
        first_k = k;
        check("single_last", bus.m_last, v.exp_words == 1);
      end
      if (bus.done) begin
        done_k = k;
        check("busy_at_done", bus.busy, 0);
        check("valid_at_done", bus.m_valid, 0);
        if (v.exp_words > 0)
          check("end_addr", bus.rom_addr, (int'(v.addr) + v.exp_words) % 64);
      end
      bus.m_ready = v.pat[k % v.pat_len];
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", bus.m_data, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", bus.m_data, e.data);
          check("last", bus.m_last, e.last);
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      pdata = bus.m_data; plast = bus.m_last; paddr = bus.rom_addr;
      k++;
    end
    check("done_seen", done_k >= 0, 1);
    check("done_cycle", done_k, v.exp_busy);
    check("busy_cycles", busy_cnt, v.exp_busy);
    if (v.exp_words > 0) check("first_latency", first_k, 1);
    check("missing_words", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int   n;
    vec_t v;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_addr", bus.rom_addr, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // addr, len, ready pattern, pattern length, inject start, busy cycles, words
    vecs[0] = '{6'd0,  7'd4,   8'hFF, 1, 1'b0, 5,  4};
    vecs[1] = '{6'd62, 7'd4,   8'hFF, 1, 1'b0, 5,  4};
    vecs[2] = '{6'd10, 7'd3,   8'hD3, 8, 1'b0, 7,  3};
    vecs[3] = '{6'd3,  7'd0,   8'hFF, 1, 1'b0, 0,  0};
    vecs[4] = '{6'd50, 7'd1,   8'hFF, 1, 1'b0, 2,  1};
    vecs[5] = '{6'd17, 7'd100, 8'hFF, 1, 1'b0, 65, 64};
    vecs[6] = '{6'd8,  7'd6,   8'hFF, 1, 1'b1, 7,  6};
    vecs[7] = '{6'd0,  7'd64,  8'hFF, 1, 1'b0, 65, 64};
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start accepted in the done cycle of the previous command.
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 6'd20; bus.length = 7'd2; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", bus.done, 1);
    bus.start = 1'b1; bus.start_addr = 6'd40; bus.length = 7'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accept", bus.busy, 1);
    check("b2b_done_clear", bus.done, 0);
    @(negedge clk);
    check("b2b_valid", bus.m_valid, 1);
    check("b2b_data", bus.m_data, 16'h1028);
    check("b2b_last", bus.m_last, 1);
    @(negedge clk);
    check("b2b_second_done", bus.done, 1);

    // Reset in the middle of a burst.
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 6'd5; bus.length = 7'd10; bus.m_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k >= 1) check("pre_rst_data", bus.m_data, 16'h1005 + 16'(k - 1));
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", bus.rom_addr, 0);
    check("arst_data", bus.m_data, 0);
    check("arst_valid", bus.m_valid, 0);
    check("arst_last", bus.m_last, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", bus.done, 0);
    check("post_rst_valid", bus.m_valid, 0);
    v = '{6'd7, 7'd2, 8'hFF, 1, 1'b0, 3, 2};
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Sequential reader for the 64x16 asynchronous-read ROM.
- On a start command it drives the ROM address port across a contiguous, wrap-around address range.
- It registers each returned word and streams it out on a valid/ready interface, with a last flag and a done pulse.
- It sits between the ROM and any downstream consumer, such as a pattern generator or coefficient loader.

Parameters:
- ADDR_WIDTH, 6: ROM address width.
- DATA_WIDTH, 16: ROM/stream data width.
- MEM_CAPACITY, 64: number of ROM words; must be <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  start request, sampled in IDLE only.
- start_addr  input  ADDR_WIDTH  first address; values >= MEM_CAPACITY are taken modulo MEM_CAPACITY.
- length  input  ADDR_WIDTH+1  number of words to read; 0 = no-op; values > MEM_CAPACITY are clamped to MEM_CAPACITY.
- rom_addr  output  ADDR_WIDTH  registered address to the ROM.
- rom_rdata  input  DATA_WIDTH  combinational ROM read data for rom_addr.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready.
- m_last  output  1  marks the final word of a burst; qualified by m_valid.
- busy  output  1  high from the accepted start until the final handshake.
- done  output  1  one-cycle pulse at the end of every accepted command.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; rom_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0; remaining-word counter=0. Reset mid-burst aborts the burst with no done pulse.
- FSM states: IDLE and STREAM.
- IDLE + start, length!=0, at edge E0:
  - latch rom_addr=start_addr mod MEM_CAPACITY and remaining=min(length, MEM_CAPACITY);
  - busy=1, go to STREAM.
- IDLE + start, length==0: done=1 for the next cycle only; busy stays 0; no stream activity.
- start while in STREAM is ignored.
- Load condition in STREAM: remaining>0 and (m_valid==0 or m_ready==1).
  - On a load: m_data<=rom_rdata; m_valid<=1; m_last<=(remaining==1); remaining decrements.
  - rom_addr advances: MEM_CAPACITY-1 wraps to 0, otherwise +1.
- Handshake: occurs on an edge where m_valid && m_ready.
  - A handshake with no concurrent load clears m_valid and m_last.
  - While m_valid && !m_ready, m_data, m_last and rom_addr hold stable.
- Latency: first word is valid after edge E1, i.e. one cycle after start is accepted.
- Throughput: with m_ready held high, word k is presented after edge E(1+k), one word per cycle with no bubbles.
- Completion: the edge that handshakes the word with m_last=1 does the following:
  - m_valid<=0, m_last<=0, busy<=0, done<=1 for one cycle;
  - state returns to IDLE;
  - rom_addr holds the address after the last word.
- A new start is accepted during the done cycle.
- Full-capacity read (length=64) wraps and reads every word exactly once.
- m_last is never asserted without m_valid.
- Single-word burst: m_valid and m_last rise together.

Test Plan:
- ROM model for all scenarios: rom_rdata = 16'h1000 + rom_addr.
- Reset: assert rst_n=0 mid-burst (start_addr=5, length=10, after 3 words) -> all outputs 0 immediately (asynchronous), no done pulse; a new start after release streams from its own start_addr.
- Basic: start_addr=0, length=4, m_ready=1 -> m_data 0x1000..0x1003 on four consecutive cycles, first valid one cycle after start; m_last only on 0x1003; done pulse on the cycle after; busy high exactly 5 cycles.
- Wrap: start_addr=62, length=4 -> 0x103E, 0x103F, 0x1000, 0x1001; m_last on 0x1001.
- Backpressure: start_addr=10, length=3, m_ready toggling 1,0,0,1,0,1 -> every word delivered exactly once in order 0x100A..0x100C; m_data stable while stalled.
- Edge lengths:
  - length=0 -> done pulse only, no m_valid.
  - length=1 -> m_valid and m_last together.
  - length=100 -> clamped to 64 words, all addresses once.
  - start asserted during STREAM -> ignored.
